// File: rtl/key_event_queue.sv
// Turns the debounced 16-key level vector into press events (code = key index - 1)
// queued in a show-ahead FIFO for the CPU port; repeat presses merge and flag overflow.
module key_event_queue #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [16:1]   keys,
  input  logic          rd_en,
  input  logic          clr_ovf,
  output logic [3:0]    key_code,
  output logic          key_valid,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [16:1]   keys_d;
  logic [16:1]   pending;
  logic [16:1]   rise;
  logic [16:1]   lowest;
  logic [16:1]   grant;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          push;
  logic          pop;
  logic          push_ok;
  logic          ovf_set;

  function automatic logic [3:0] encode(input logic [16:1] onehot);
    logic [3:0] code;
    code = '0;
    for (int i = 1; i <= 16; i++) begin
      if (onehot[i]) code = 4'(i - 1);
    end
    return code;
  endfunction

  assign rise    = keys & ~keys_d;
  // Two's-complement trick isolates the lowest set pending bit.
  assign lowest  = pending & (~pending + 16'd1);
  assign pop     = rd_en && (count_q != '0);
  // A full queue still accepts a push when it is popped in the same cycle.
  assign push_ok = (count_q != FULL) || pop;
  assign grant   = push_ok ? lowest : '0;
  assign push    = |grant;
  assign ovf_set = |(rise & pending & ~grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_d   <= '0;
      pending  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      keys_d  <= keys;
      pending <= (pending & ~grant) | rise;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Storage carries no reset; count gates what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= encode(grant);
  end

  assign key_valid = (count_q != '0);
  assign key_code  = key_valid ? mem[rd_ptr] : 4'd0;
  assign count     = count_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model of press events.
module tb_key_event_queue;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [16:1]   keys = '0;
  logic          rd_en = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [3:0]    key_code;
  logic          key_valid;
  logic [AW:0]   count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          q[$];
  bit [16:1]   m_prev;
  bit [16:1]   m_pend;
  bit          m_ovf;

  key_event_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .keys(keys), .rd_en(rd_en), .clr_ovf(clr_ovf),
    .key_code(key_code), .key_valid(key_valid), .count(count), .overflow(overflow)
  );

  always #10 clk = ~clk;

  function automatic int exp_code();
    return (q.size() > 0) ? q[0] : 0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_prev = '0;
    m_pend = '0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge();
    bit [16:1] rise;
    bit        do_pop;
    bit        lost;
    int        g;
    rise   = keys & ~m_prev;
    do_pop = rd_en && (q.size() > 0);
    g      = 0;
    if (q.size() < DEPTH || do_pop) begin
      for (int i = 1; i <= 16; i++) begin
        if (m_pend[i]) begin
          g = i;
          break;
        end
      end
    end
    lost = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (rise[i] && m_pend[i] && i != g) lost = 1'b1;
    end
    if (do_pop) void'(q.pop_front());
    if (g != 0) begin
      q.push_back(g - 1);
      m_pend[g] = 1'b0;
    end
    m_pend = m_pend | rise;
    if (lost)         m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    m_prev = keys;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    keys = '0; rd_en = 0; clr_ovf = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (count !== '0)     begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (key_valid !== 0)  begin errors++; $display("FAIL reset_valid got %0b want 0", key_valid); end
    checks++; if (key_code !== 0)   begin errors++; $display("FAIL reset_code got %0d want 0", key_code); end
    checks++; if (overflow !== 0)   begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
  endtask

  task automatic test_single_press();
    apply_reset();
    keys = 16'h0010;
    tick();
    checks++; if (key_valid !== 0) begin errors++; $display("FAIL single_early got %0b want 0", key_valid); end
    tick();
    checks++; if (key_valid !== 1 || key_code !== 4'd4)
      begin errors++; $display("FAIL single_code got v=%0b c=%0d want v=1 c=4", key_valid, key_code); end
    repeat (8) tick();
    keys = '0;
    repeat (4) tick();
    checks++; if (count !== 1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
  endtask

  task automatic test_simultaneous();
    int exp[3] = '{0, 8, 15};
    apply_reset();
    keys = 16'h8101;
    tick();
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (count !== (AW+1)'(k)) begin errors++; $display("FAIL simul_fill got %0d want %0d", count, k); end
    end
    rd_en = 1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (key_valid !== 1 || key_code !== 4'(exp[k]))
        begin errors++; $display("FAIL simul_order got %0d want %0d", key_code, exp[k]); end
      tick();
    end
    rd_en = 0;
    checks++; if (key_valid !== 0) begin errors++; $display("FAIL simul_empty got %0b want 0", key_valid); end
    keys = '0;
    tick();
  endtask

  task automatic test_full();
    apply_reset();
    for (int k = 1; k <= 9; k++) begin
      keys = '0; keys[k] = 1'b1;
      tick();
      keys = '0;
      tick();
    end
    repeat (3) tick();
    checks++; if (count !== (AW+1)'(DEPTH)) begin errors++; $display("FAIL full_count got %0d want %0d", count, DEPTH); end
    checks++; if (overflow !== 0) begin errors++; $display("FAIL full_ovf got %0b want 0", overflow); end
    rd_en = 1;
    tick();
    rd_en = 0;
    checks++; if (count !== (AW+1)'(DEPTH)) begin errors++; $display("FAIL full_popcount got %0d want %0d", count, DEPTH); end
    checks++; if (key_code !== 4'd1) begin errors++; $display("FAIL full_head got %0d want 1", key_code); end
    // Drain and confirm the ninth press landed last
    for (int k = 1; k <= 8; k++) begin
      checks++; if (key_code !== 4'(k)) begin errors++; $display("FAIL full_drain got %0d want %0d", key_code, k); end
      rd_en = 1;
      tick();
    end
    rd_en = 0;
  endtask

  task automatic test_overflow();
    int twos;
    apply_reset();
    for (int k = 5; k <= 12; k++) begin
      keys = '0; keys[k] = 1'b1;
      tick();
      keys = '0;
      tick();
    end
    tick();
    keys = 16'h0004; tick();
    keys = '0;       tick();
    keys = 16'h0004; tick();
    keys = '0;       tick();
    checks++; if (overflow !== 1) begin errors++; $display("FAIL ovf_set got %0b want 1", overflow); end
    twos = 0;
    for (int k = 0; k < 12; k++) begin
      if (key_valid && key_code == 4'd2) twos++;
      rd_en = 1;
      tick();
    end
    rd_en = 0;
    checks++; if (twos !== 1) begin errors++; $display("FAIL ovf_merge got %0d want 1", twos); end
    checks++; if (overflow !== 1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
    clr_ovf = 1; tick(); clr_ovf = 0;
    checks++; if (overflow !== 0) begin errors++; $display("FAIL ovf_clear got %0b want 0", overflow); end
  endtask

  task automatic test_read_edges();
    apply_reset();
    rd_en = 1;
    repeat (5) tick();
    rd_en = 0;
    checks++; if (count !== 0 || key_valid !== 0)
      begin errors++; $display("FAIL empty_read got cnt=%0d v=%0b want 0", count, key_valid); end
    keys = 16'h0040;
    repeat (2) tick();
    checks++; if (count !== 1 || key_code !== 4'd6)
      begin errors++; $display("FAIL edge_first got cnt=%0d c=%0d want 1/6", count, key_code); end
    keys = 16'h0002;
    tick();
    rd_en = 1;
    tick();
    rd_en = 0;
    checks++; if (count !== 1 || key_code !== 4'd1)
      begin errors++; $display("FAIL push_pop got cnt=%0d c=%0d want 1/1", count, key_code); end
    keys = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    keys = 16'h00FF;
    repeat (6) tick();
    checks++; if (count !== 5) begin errors++; $display("FAIL mid_count got %0d want 5", count); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 0 || key_valid !== 0 || key_code !== 0 || overflow !== 0)
      begin errors++; $display("FAIL async_reset got cnt=%0d v=%0b c=%0d o=%0b want 0", count, key_valid, key_code, overflow); end
    keys = 16'h0008;
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    model_reset();
    repeat (6) tick();
    checks++; if (count !== 1 || key_code !== 4'd3)
      begin errors++; $display("FAIL held_key got cnt=%0d c=%0d want 1/3", count, key_code); end
    keys = '0;
    tick();
  endtask

  task automatic test_random();
    bit [15:0] flip;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      flip = '0;
      for (int b = 0; b < 16; b++) flip[b] = ($urandom_range(0, 11) == 0);
      keys    = keys ^ flip;
      rd_en   = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 20 : 70));
      clr_ovf = ($urandom_range(0, 29) == 0);
      tick();
      checks++; if (count !== (AW+1)'(q.size()))
        begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", c, count, q.size()); end
      checks++; if (key_valid !== (q.size() > 0))
        begin errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", c, key_valid, q.size() > 0); end
      checks++; if (key_code !== 4'(exp_code()))
        begin errors++; $display("FAIL rnd_code cyc %0d got %0d want %0d", c, key_code, exp_code()); end
      checks++; if (overflow !== m_ovf)
        begin errors++; $display("FAIL rnd_ovf cyc %0d got %0b want %0b", c, overflow, m_ovf); end
    end
    keys = '0; rd_en = 0; clr_ovf = 0;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_simultaneous();
    test_full();
    test_overflow();
    test_read_edges();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_queue.md
# key_event_queue

Converts the 16-bit debounced key level vector from the matrix-keypad scanner into discrete key-press events. Each new press (0→1 transition of a key bit) is encoded as a 4-bit key code and queued in a small FIFO. The CPU I/O port pops codes one at a time with a show-ahead read interface. The block sits directly downstream of the keypad scanner and upstream of the CPU input port.

## Interface
- DEPTH, 8: FIFO entries; power of two, ≥2.
- AW, $clog2(DEPTH): pointer width; derived, not overridden.

- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- keys  in  16 [16:1]  key levels from scanner, 1 = pressed; synchronous to clk.
- rd_en  in  1  pop request; acts only when key_valid = 1.
- clr_ovf  in  1  clears the overflow flag.
- key_code  out  4  head-of-queue code = key index − 1 (keys[1]→0, keys[16]→15); 0 when empty.
- key_valid  out  1  queue non-empty.
- count  out  AW+1  entries currently queued, 0..DEPTH.
- overflow  out  1  sticky; a press was lost.

## Operation
- keys_d register holds the previous keys value; it resets to 0.
- Rise vector: rise = keys & ~keys_d. A release generates no event.
- Pending register (16 bits, reset 0): pending_next = (pending & ~grant) | rise.
- Grant:
  - One-hot grant selects the lowest-index set pending bit.
  - Grant is issued only when push is allowed: count < DEPTH, or (count == DEPTH and a pop occurs in the same cycle).
  - Otherwise grant = 0 and pending is held.
- Push: on grant, write the granted index − 1 to mem[wr_ptr] and increment wr_ptr (mod DEPTH).
- Pop: on rd_en & key_valid, increment rd_ptr (mod DEPTH). rd_en while empty is ignored.
- count update:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged.
- Multiple simultaneous presses queue in ascending index order, one per cycle.
- A key released before its grant still produces its event, because the press is latched in pending.
- Overflow:
  - Set when (rise & pending & ~grant) ≠ 0, i.e. a second press of a key whose first press is not yet queued; the two presses merge into one event.
  - When rise and grant hit the same bit in one cycle, pending stays set for the new press and overflow is not set.
  - clr_ovf clears overflow. If set and clear occur in the same cycle, set wins.
- FIFO full does not set overflow. Presses wait in pending, at most one per key.
- key_code/key_valid are combinational from mem[rd_ptr]/count. No bubble when the FIFO is full and popped every cycle.

## Timing
- All registers update on the posedge of clk.
- Reset (asynchronous assert, synchronous-release usage): keys_d = 0, pending = 0, wr_ptr = rd_ptr = 0, count = 0, overflow = 0, key_valid = 0, key_code = 0.
- mem contents are not reset.
- Reset mid-operation discards all queued and pending events. A key held through reset release produces one event after reset, because keys_d restarts at 0.
- Latency:
  - keys[i] first sampled high in cycle N → pending[i] set at the end of N.
  - Grant/push occurs in N+1 if the FIFO is not full.
  - key_valid = 1 with key_code = i−1 in N+2 if the queue was empty.
- Pop takes effect at the clock edge. The next entry, or key_valid = 0, is visible in the following cycle.
- Throughput: at most one push and one pop per cycle.

## Test plan
- Single press: keys = 0x0010 (keys[5]) held 10 cycles, then released → exactly one entry; key_code = 4 with key_valid = 1 two cycles after the rise; count = 1; a release event is never queued.
- Simultaneous press: keys goes 0 → 0x8101 (keys[1], keys[9], keys[16]) in one cycle, no reads → codes 0, 8, 15 queued on consecutive cycles; count = 3; popping returns 0, 8, 15 in order.
- Full FIFO: 9 distinct single presses with no reads (DEPTH = 8) → count = 8, the 9th press is held in pending, overflow = 0. One pop → the 9th code is queued in the same cycle and count stays 8.
- Overflow: fill the FIFO, then press/release/press keys[3] while full → overflow = 1 and only one code 2 is queued after a pop. Assert clr_ovf for 1 cycle → overflow = 0.
- Read edge cases: rd_en held with an empty queue → count stays 0 and no pointer movement. Simultaneous push and pop at count = 1 → count remains 1 and key_code advances to the new entry.
- Reset mid-operation: assert rst_n = 0 with count = 5 and pending ≠ 0 → all outputs read 0 immediately (asynchronously). A key held across reset release yields exactly one event after release.
